phys_free_list: RTL and testbench

//  Parametrised physical-register free list for the OOO core. Circular FIFO of free pd tags.

---
 rtl/phys_free_list_pkg.sv | 12 +
 rtl/phys_free_list.sv | 101 ++++++++++
 tb/tb_phys_free_list.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/phys_free_list_pkg.sv
// Shared core types for the rename stage: free-list geometry and physical tag width.
package rv32i_types;

  localparam int unsigned FREE_LIST_DEPTH      = 32;
  localparam int unsigned FREE_LIST_ADDR_WIDTH = $clog2(FREE_LIST_DEPTH);
  localparam int unsigned PHYS_REG_BITS        = 6;
  localparam int unsigned NUM_ARCH_REGS        = 32;
  localparam int unsigned NUM_FL_CKPT          = 4;

  typedef logic [FREE_LIST_ADDR_WIDTH:0] fl_ptr_t;

endpackage

// File: rtl/phys_free_list.sv
// Physical-register free list: circular FIFO of free pd tags with flush recovery.
// Define FREE_LIST_CKPT_EN to add branch checkpoints of the head pointer.
module phys_free_list
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH      = FREE_LIST_DEPTH,
  parameter int unsigned DATA_WIDTH = PHYS_REG_BITS,
  parameter int unsigned NUM_ARCH   = NUM_ARCH_REGS,
  parameter int unsigned NUM_CKPT   = NUM_FL_CKPT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dequeue,
  output logic [DATA_WIDTH-1:0]      pd_out,
  output logic                       empty,
  input  logic                       enqueue,
  input  logic [DATA_WIDTH-1:0]      enq_pd,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       flush,
`ifdef FREE_LIST_CKPT_EN
  input  logic                       ckpt_save,
  input  logic                       ckpt_restore,
  input  logic [$clog2(NUM_CKPT)-1:0] ckpt_id,
`endif
  output logic                       err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           head, tail;
  logic [AW:0]           head_nxt, tail_nxt, head_inc;
  logic                  restore, push_ok, pop_req, pop_ok;

`ifdef FREE_LIST_CKPT_EN
  logic [AW:0]           ckpt_slot [NUM_CKPT];
`endif

  assign count  = tail - head;
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign pd_out = mem[head[AW-1:0]];

  always_comb begin
    restore = 1'b0;
`ifdef FREE_LIST_CKPT_EN
    restore = ckpt_restore;
`endif
    push_ok  = enqueue & ~full;
    // Flush and restore both overwrite head, so a same-cycle pop is dropped silently.
    pop_req  = dequeue & ~flush & ~restore;
    pop_ok   = pop_req & ~empty;
    head_inc = head + (AW+1)'(pop_ok);
    tail_nxt = tail + (AW+1)'(push_ok);
    head_nxt = head;
    if (flush)
      head_nxt = {~tail_nxt[AW], tail_nxt[AW-1:0]};
`ifdef FREE_LIST_CKPT_EN
    else if (ckpt_restore)
      head_nxt = ckpt_slot[ckpt_id];
`endif
    else if (pop_ok)
      head_nxt = head_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= {1'b1, {AW{1'b0}}};
      err  <= 1'b0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      if ((enqueue & full) | (pop_req & empty))
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= DATA_WIDTH'(NUM_ARCH + i);
    end else if (push_ok) begin
      mem[tail[AW-1:0]] <= enq_pd;
    end
  end

`ifdef FREE_LIST_CKPT_EN
  // Restore reads the slot through head_nxt before the save below overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CKPT; i++)
        ckpt_slot[i] <= '0;
    end else if (ckpt_save) begin
      ckpt_slot[ckpt_id] <= head_inc;
    end
  end
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: directed scenarios plus randomized traffic
// compared every cycle against an unbounded-index history model of the free list.
module tb_phys_free_list;
  import rv32i_types::*;

  localparam int D  = FREE_LIST_DEPTH;
  localparam int DW = PHYS_REG_BITS;
  localparam int NA = NUM_ARCH_REGS;
  localparam int NC = NUM_FL_CKPT;
  localparam int CW = $clog2(NC);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 dequeue = 1'b0;
  logic                 enqueue = 1'b0;
  logic [DW-1:0]        enq_pd = '0;
  logic                 flush = 1'b0;
  logic                 ckpt_save = 1'b0;
  logic                 ckpt_restore = 1'b0;
  logic [CW-1:0]        ckpt_id = '0;
  logic [DW-1:0]        pd_out;
  logic                 empty, full, err;
  logic [$clog2(D):0]   count;

  phys_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .dequeue      (dequeue),
    .pd_out       (pd_out),
    .empty        (empty),
    .enqueue      (enqueue),
    .enq_pd       (enq_pd),
    .full         (full),
    .count        (count),
    .flush        (flush),
`ifdef FREE_LIST_CKPT_EN
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
    .ckpt_id      (ckpt_id),
`endif
    .err          (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: every tag ever placed in the list, in order; head/tail are unbounded indices.
  int hist[$];
  int mh, mt;
  bit merr;
  int slot[NC];
  bit saved[NC];
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < D; i++) hist.push_back(NA + i);
    mh = 0;
    mt = D;
    merr = 1'b0;
    for (int i = 0; i < NC; i++) begin
      slot[i]  = 0;
      saved[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit deq, input bit enq, input int pd,
                                     input bit fl, input bit sv, input bit rs, input int id);
    int  cnt;
    bit  push, pop, popreq;
    int  save_val;
    cnt    = mt - mh;
    push   = enq && (cnt != D);
    popreq = deq && !fl && !rs;
    pop    = popreq && (cnt != 0);
    if ((enq && cnt == D) || (popreq && cnt == 0)) merr = 1'b1;
    save_val = mh + (pop ? 1 : 0);
    if (push) begin
      hist.push_back(pd);
      mt++;
    end
    if (fl)       mh = mt - D;
    else if (rs)  mh = slot[id];
    else if (pop) mh++;
    if (sv) begin
      slot[id]  = save_val;
      saved[id] = 1'b1;
    end
  endfunction

  task automatic cyc(input bit deq, input bit enq, input int pd,
                     input bit fl = 1'b0, input bit sv = 1'b0, input bit rs = 1'b0,
                     input int id = 0);
    dequeue      = deq;
    enqueue      = enq;
    enq_pd       = DW'(pd);
    flush        = fl;
    ckpt_save    = sv;
    ckpt_restore = rs;
    ckpt_id      = CW'(id);
    @(posedge clk);
    model_step(deq, enq, pd, fl, sv, rs, id);
    #1;
    dequeue      = 1'b0;
    enqueue      = 1'b0;
    flush        = 1'b0;
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1 chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(mt - mh));
      check("full",  32'(full),  32'((mt - mh) == D));
      check("empty", 32'(empty), 32'((mt - mh) == 0));
      check("err",   32'(err),   32'(merr));
      if (mt != mh) check("pd_out", 32'(pd_out), 32'(hist[mh]));
    end
  end

  initial begin
    bit deq, enq, fl, sv, rs;
    int pd, id, phase;

    // Reset state
    model_reset();
    #12 rst = 1'b0;
    #1;
    check("rst_pd_out", 32'(pd_out), 32);
    check("rst_count",  32'(count), 32);
    check("rst_full",   32'(full), 1);
    check("rst_empty",  32'(empty), 0);
    check("rst_err",    32'(err), 0);
    chk_en = 1'b1;

    // Drain in order, then pop from empty
    for (int i = 0; i < D; i++) begin
      check("drain_order", 32'(pd_out), 32'(32 + i));
      cyc(1, 0, 0);
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_count", 32'(count), 0);
    check("drain_err",   32'(err), 0);
    cyc(1, 0, 0);
    check("underflow_err",   32'(err), 1);
    check("underflow_count", 32'(count), 0);

    // Push and pop together while empty
    do_reset();
    for (int i = 0; i < D; i++) cyc(1, 0, 0);
    cyc(1, 1, 7);
    check("pushpop_err",    32'(err), 1);
    check("pushpop_pd_out", 32'(pd_out), 7);
    check("pushpop_count",  32'(count), 1);

    // Wraparound ordering
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 5 + i);
    check("wrap_full", 32'(full), 1);
    for (int i = 0; i < D; i++) begin
      check("wrap_order", 32'(pd_out), (i < 12) ? 32'(52 + i) : 32'(5 + i - 12));
      cyc(1, 0, 0);
    end
    check("wrap_empty", 32'(empty), 1);
    cyc(0, 1, 9);
    check("wrap_reuse", 32'(pd_out), 9);

    // Flush with concurrent push (and an ignored pop)
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    cyc(1, 1, 3, 1);
    check("flush_count",  32'(count), 32);
    check("flush_full",   32'(full), 1);
    check("flush_pd_out", 32'(pd_out), 33);
    check("flush_err",    32'(err), 0);

`ifdef FREE_LIST_CKPT_EN
    // Checkpoint save with pop, later restore
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 2);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 2);
    check("ckpt_pd_out", 32'(pd_out), 37);
    check("ckpt_count",  32'(count), 27);
    check("ckpt_err",    32'(err), 0);
`endif

    // Randomized traffic with alternating drain/fill bias
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      phase = (n / 200) % 2;
      deq = ($urandom_range(99) < (phase ? 75 : 30));
      enq = ($urandom_range(99) < (phase ? 30 : 75));
      pd  = int'($urandom_range((1 << DW) - 1));
      fl  = ($urandom_range(99) < 2);
      sv  = 1'b0;
      rs  = 1'b0;
      id  = int'($urandom_range(NC - 1));
`ifdef FREE_LIST_CKPT_EN
      sv = ($urandom_range(99) < 6);
      rs = ($urandom_range(99) < 4) && saved[id] && (mt - slot[id] < D);
`endif
      cyc(deq, enq, pd, fl, sv, rs, id);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
